seg7_scan_driver: RTL and testbench

//  Time-multiplexed 8-digit 7-segment scan driver and the consumer of the 32-bit display word held by the
//  APB display peripheral. Per-digit hex decode, per-digit blanking and decimal points, 16-level brightness
//  PWM and an anti-ghosting guard band. Inputs are shadowed once per frame so a display update never tears.

---
 rtl/seg7_scan_driver.sv | 130 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Eight-digit multiplexed 7-segment scan driver: per-slot hex decode, blanking, DP, 16-level PWM and guard band.
// Display inputs are captured once per frame so a frame is never drawn from two different words.
module seg7_hex_dec (
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);
  always_comb begin
    o_seg = 7'h00;
    unique case (i_nib)
      4'h0: o_seg = 7'h3F;
      4'h1: o_seg = 7'h06;
      4'h2: o_seg = 7'h5B;
      4'h3: o_seg = 7'h4F;
      4'h4: o_seg = 7'h66;
      4'h5: o_seg = 7'h6D;
      4'h6: o_seg = 7'h7D;
      4'h7: o_seg = 7'h07;
      4'h8: o_seg = 7'h7F;
      4'h9: o_seg = 7'h6F;
      4'hA: o_seg = 7'h77;
      4'hB: o_seg = 7'h7C;
      4'hC: o_seg = 7'h39;
      4'hD: o_seg = 7'h5E;
      4'hE: o_seg = 7'h79;
      4'hF: o_seg = 7'h71;
      default: o_seg = 7'h00;
    endcase
  end
endmodule

module seg7_scan_driver #(
  parameter int DIGITS     = 8,
  parameter int DIV_LOG2   = 17,
  parameter int GUARD      = 4,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk_i,
  input  logic                  presetn_i,
  input  logic [4*DIGITS-1:0]   num_i,
  input  logic [DIGITS-1:0]     blank_i,
  input  logic [DIGITS-1:0]     dp_i,
  input  logic [3:0]            bright_i,
  output logic [6:0]            cath_o,
  output logic                  dp_o,
  output logic [DIGITS-1:0]     an_o,
  output logic                  frame_o
);
  localparam int                  IDX_W    = $clog2(DIGITS);
  localparam logic [DIV_LOG2-1:0] TICK_MAX = '1;
  localparam logic [DIV_LOG2-1:0] GUARD_T  = DIV_LOG2'(GUARD);
  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic                POL      = (ACTIVE_LOW != 0);

  logic [DIV_LOG2-1:0] r_tick;
  logic [IDX_W-1:0]    r_idx;
  logic [4*DIGITS-1:0] r_sh_num;
  logic [DIGITS-1:0]   r_sh_blank;
  logic [DIGITS-1:0]   r_sh_dp;
  logic                r_frame;
  logic [DIGITS-1:0]   r_an;
  logic [6:0]          r_cath;
  logic                r_dp;

  logic                w_tick_wrap;
  logic                w_frame_end;
  logic                w_lit;
  logic [3:0]          w_nib;
  logic [6:0]          w_seg;
  logic [DIGITS-1:0]   w_an;

  assign w_tick_wrap = (r_tick == TICK_MAX);
  assign w_frame_end = w_tick_wrap && (r_idx == IDX_LAST);

  always_ff @(posedge clk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      r_tick <= '0;
      r_idx  <= '0;
    end else begin
      r_tick <= r_tick + DIV_LOG2'(1);
      if (w_tick_wrap) r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
    end
  end

  // Reset shadows blank every digit, so the first frame after reset is dark.
  always_ff @(posedge clk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      r_sh_num   <= '0;
      r_sh_blank <= '1;
      r_sh_dp    <= '0;
      r_frame    <= 1'b0;
    end else begin
      r_frame <= w_frame_end;
      if (w_frame_end) begin
        r_sh_num   <= num_i;
        r_sh_blank <= blank_i;
        r_sh_dp    <= dp_i;
      end
    end
  end

  // Duty compares the top nibble of the slot counter; the guard keeps slot edges dark.
  assign w_lit = (r_tick >= GUARD_T) && (r_tick[DIV_LOG2-1 -: 4] <= bright_i) && !r_sh_blank[r_idx];
  assign w_nib = r_sh_num[{r_idx, 2'b00} +: 4];

  seg7_hex_dec u_dec (
    .i_nib (w_nib),
    .o_seg (w_seg)
  );

  for (genvar d = 0; d < DIGITS; d++) begin : g_an
    assign w_an[d] = w_lit && (r_idx == IDX_W'(d));
  end

  always_ff @(posedge clk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      r_an   <= '0;
      r_cath <= '0;
      r_dp   <= 1'b0;
    end else begin
      r_an   <= w_an;
      r_cath <= w_lit ? w_seg : 7'h00;
      r_dp   <= w_lit && r_sh_dp[r_idx];
    end
  end

  assign an_o    = r_an ^ {DIGITS{POL}};
  assign cath_o  = r_cath ^ {7{POL}};
  assign dp_o    = r_dp ^ POL;
  assign frame_o = r_frame;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver at DIV_LOG2=4, GUARD=2, active-low: cycle model, per-frame vector table, corner sequences.
module tb_seg7_scan_driver;
  localparam int DL = 4;
  localparam int G  = 2;

  logic        clk = 1'b0;
  logic        presetn;
  logic [31:0] num;
  logic [7:0]  blank, dp;
  logic [3:0]  bright;
  logic [6:0]  cath_o;
  logic        dp_o;
  logic [7:0]  an_o;
  logic        frame_o;

  seg7_scan_driver #(.DIGITS(8), .DIV_LOG2(DL), .GUARD(G), .ACTIVE_LOW(1)) dut (
    .clk_i(clk), .presetn_i(presetn), .num_i(num), .blank_i(blank), .dp_i(dp),
    .bright_i(bright), .cath_o(cath_o), .dp_o(dp_o), .an_o(an_o), .frame_o(frame_o)
  );

  always #5 clk = ~clk;

  logic [6:0] DEC [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: a free-running cycle count since reset plus the frame-captured display word.
  int          cnt;
  logic [31:0] m_num;
  logic [7:0]  m_blank, m_dp;

  task automatic model_reset();
    cnt = 0; m_num = 32'h0; m_blank = 8'hFF; m_dp = 8'h00;
  endtask

  task automatic run_model(input int ncyc, input bit rnd);
    int tick, idx;
    bit lit;
    logic [7:0]  onehot, e_an;
    logic [6:0]  e_cath;
    logic        e_dp, e_fr;
    logic [3:0]  nib;
    for (int i = 0; i < ncyc; i++) begin
      if (rnd) begin
        if ($urandom_range(0, 15) == 0) num    = $urandom;
        if ($urandom_range(0, 31) == 0) blank  = 8'($urandom);
        if ($urandom_range(0, 31) == 0) dp     = 8'($urandom);
        if ($urandom_range(0, 7)  == 0) bright = 4'($urandom);
      end
      tick = cnt % 16;
      idx  = (cnt / 16) % 8;
      // With a 16-cycle slot the 4-bit duty field is the whole slot position.
      lit  = (tick >= G) && (tick <= int'(bright)) && !m_blank[idx];
      nib  = m_num[4*idx +: 4];
      onehot = 8'd1 << idx;
      e_an   = lit ? ~onehot : 8'hFF;
      e_cath = lit ? ~DEC[nib] : 7'h7F;
      e_dp   = ~(lit && m_dp[idx]);
      e_fr   = (cnt % 128 == 127);
      if (cnt % 128 == 127) begin
        m_num = num; m_blank = blank; m_dp = dp;
      end
      cnt++;
      @(posedge clk); #1;
      chk($sformatf("model cnt=%0d {an,cath,dp,frame}", cnt), {an_o, cath_o, dp_o, frame_o},
          {e_an, e_cath, e_dp, e_fr});
    end
  endtask

  task automatic wait_frame(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (frame_o) begin ok = 1'b1; break; end
    end
    if (!ok) chk("frame_o timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [31:0] num;
    logic [7:0]  blank;
    logic [7:0]  dp;
    logic [3:0]  bright;
    int          lit_cyc;
    int          dp_cyc;
  } vec_t;

  vec_t tbl [6];

  initial begin
    bit ok;
    int lit_n, dp_n, multi, bad_old, bad_new, lit_old, lit_new, last, npulse;

    tbl[0] = '{32'h76543210, 8'h00, 8'h00, 4'hF, 112, 0};
    tbl[1] = '{32'h76543210, 8'h00, 8'h00, 4'h7, 48,  0};
    tbl[2] = '{32'h76543210, 8'h00, 8'h00, 4'h0, 0,   0};
    tbl[3] = '{32'h89ABCDEF, 8'h0A, 8'h01, 4'hF, 84,  14};
    tbl[4] = '{32'h12345678, 8'hFF, 8'hFF, 4'hF, 0,   0};
    tbl[5] = '{32'hDEADBEEF, 8'h00, 8'hFF, 4'h2, 8,   8};

    num = 32'h76543210; blank = 8'h00; dp = 8'h00; bright = 4'hF; presetn = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset outputs", {an_o, cath_o, dp_o, frame_o}, {8'hFF, 7'h7F, 1'b1, 1'b0});

    // Dark first frame, then digits 0..7 in their slots.
    @(negedge clk); presetn = 1'b1; model_reset();
    run_model(256, 1'b0);

    // Reset in the middle of slot 5 (tick 9).
    run_model(89, 1'b0);
    chk("pre-reset digit5 lit", an_o, 8'hDF);
    #2 presetn = 1'b0;
    #1 chk("async reset outputs", {an_o, cath_o, dp_o, frame_o}, {8'hFF, 7'h7F, 1'b1, 1'b0});
    repeat (2) @(negedge clk);
    presetn = 1'b1; model_reset();
    run_model(256, 1'b0);

    run_model(1500, 1'b1);

    foreach (tbl[v]) begin
      num = tbl[v].num; blank = tbl[v].blank; dp = tbl[v].dp; bright = tbl[v].bright;
      wait_frame(ok);
      lit_n = 0; dp_n = 0; multi = 0;
      for (int c = 0; c < 128; c++) begin
        @(posedge clk); #1;
        if (an_o != 8'hFF) lit_n++;
        if (!dp_o) dp_n++;
        if ($countones(~an_o) > 1) multi++;
        if ((blank[1] && !an_o[1]) || (blank[3] && !an_o[3])) multi++;
      end
      chk($sformatf("vec%0d lit cycles", v), lit_n, tbl[v].lit_cyc);
      chk($sformatf("vec%0d dp cycles", v), dp_n, tbl[v].dp_cyc);
      chk($sformatf("vec%0d anode violations", v), multi, 0);
    end

    // Word change mid-frame must wait for the next frame.
    num = 32'h0; blank = 8'h00; dp = 8'h00; bright = 4'hF;
    wait_frame(ok);
    bad_old = 0; bad_new = 0; lit_old = 0; lit_new = 0;
    for (int c = 0; c < 256; c++) begin
      @(negedge clk);
      if (c == 60) num = 32'hFFFFFFFF;
      @(posedge clk); #1;
      if (an_o != 8'hFF) begin
        if (c < 128) begin lit_old++; if (cath_o != 7'h40) bad_old++; end
        else         begin lit_new++; if (cath_o != 7'h0E) bad_new++; end
      end
    end
    chk("tear old frame bad", bad_old, 0);
    chk("tear old frame lit", lit_old, 112);
    chk("tear new frame bad", bad_new, 0);
    chk("tear new frame lit", lit_new, 112);

    // Four-frame sweep: frame period and single-anode rule.
    last = -1; npulse = 0; multi = 0;
    for (int c = 0; c < 4 * 128 + 8; c++) begin
      @(posedge clk); #1;
      if ($countones(~an_o) > 1) multi++;
      if (frame_o) begin
        if (last >= 0) chk("frame period", c - last, 128);
        last = c; npulse++;
      end
    end
    chk("sweep anode violations", multi, 0);
    chk("sweep pulse count", npulse, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
